// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-client SRAM master-bus arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int MAX_CLIENTS = 8;

    // Index of the first set bit at or after start, wrapping modulo n.
    // Walks offsets from far to near so the nearest hit is the one kept.
    function automatic logic [2:0] first_set_from(input logic [7:0] vec,
                                                  input logic [2:0] start,
                                                  input int n);
        logic [2:0] idx;
        int j;
        idx = 3'd0;
        for (int k = MAX_CLIENTS - 1; k >= 0; k--) begin
            j = (int'(start) + k) % n;
            if (k < n && vec[j[2:0]]) begin
                idx = j[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Ordered FIFO of client tags for reads in flight on the master bus.
module mem_arb_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arb_n.sv
// N-client arbiter onto one Avalon-style SRAM master, with grant lock under
// waitrequest and in-order routing of read data back to the issuing client.
module mem_arb_n
    import mem_arb_pkg::*;
#(
    parameter int N_CLIENTS   = 2,
    parameter int AW          = 20,
    parameter int DW          = 16,
    parameter int MAX_PENDING = 4,
    parameter int ARB_MODE    = 0,
    localparam int BEW        = DW / 8,
    localparam int CW         = $clog2(MAX_PENDING + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_CLIENTS*AW-1:0] cli_address,
    input  logic [N_CLIENTS*BEW-1:0] cli_byteenable,
    input  logic [N_CLIENTS-1:0]    cli_read,
    input  logic [N_CLIENTS-1:0]    cli_write,
    input  logic [N_CLIENTS*DW-1:0] cli_writedata,
    output logic [N_CLIENTS-1:0]    cli_waitrequest,
    output logic [DW-1:0]           cli_readdata,
    output logic [N_CLIENTS-1:0]    cli_readdataready,
    output logic [AW-1:0]           mem_address,
    output logic [BEW-1:0]          mem_byteenable,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DW-1:0]           mem_writedata,
    input  logic                    mem_waitrequest,
    input  logic [DW-1:0]           mem_readdata,
    input  logic                    mem_readdataready,
    output logic [CW-1:0]           pending_count,
    output logic                    err_unexpected
);
    localparam int GW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam arb_mode_e MODE = arb_mode_e'(ARB_MODE[0]);

    logic [N_CLIENTS-1:0] req;
    logic [7:0]           req8;
    logic [GW-1:0]        gnt;
    logic [GW-1:0]        gnt_q;
    logic [GW-1:0]        rr_ptr;
    logic [GW-1:0]        head;
    logic                 gnt_vld;
    logic                 locked;
    logic                 acc;
    logic                 pend_full;
    logic                 fifo_empty;

    // Full is taken from the registered count, so a same-cycle pop does not unmask reads.
    assign req  = cli_write | (cli_read & {N_CLIENTS{~pend_full}});
    assign req8 = 8'(req);

    always_comb begin
        gnt     = gnt_q;
        gnt_vld = 1'b1;
        if (!locked) begin
            gnt_vld = |req;
            if (MODE == ARB_RR) gnt = GW'(first_set_from(req8, 3'(rr_ptr), N_CLIENTS));
            else                gnt = GW'(first_set_from(req8, 3'd0, N_CLIENTS));
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (gnt_vld && reset_n) begin
            mem_address    = cli_address[int'(gnt)*AW +: AW];
            mem_byteenable = cli_byteenable[int'(gnt)*BEW +: BEW];
            mem_writedata  = cli_writedata[int'(gnt)*DW +: DW];
            mem_write      = cli_write[gnt];
            mem_read       = cli_read[gnt] & ~cli_write[gnt];
        end
    end

    assign acc = gnt_vld & (mem_read | mem_write) & ~mem_waitrequest;

    always_comb begin
        cli_waitrequest = '1;
        if (acc) cli_waitrequest[gnt] = 1'b0;
    end

    assign cli_readdata = mem_readdata;

    always_comb begin
        cli_readdataready = '0;
        if (reset_n && mem_readdataready && !fifo_empty) cli_readdataready[head] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked         <= 1'b0;
            gnt_q          <= '0;
            rr_ptr         <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (acc) begin
                locked <= 1'b0;
                rr_ptr <= (gnt == GW'(N_CLIENTS - 1)) ? '0 : gnt + GW'(1);
            end else if (gnt_vld && (mem_read || mem_write)) begin
                locked <= 1'b1;
                gnt_q  <= gnt;
            end
            if (mem_readdataready && fifo_empty) err_unexpected <= 1'b1;
        end
    end

    mem_arb_tag_fifo #(
        .W     (GW),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (acc & mem_read),
        .pop     (mem_readdataready),
        .din     (gnt),
        .head    (head),
        .count   (pending_count),
        .empty   (fifo_empty),
        .full    (pend_full)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset_n && gnt_vld) begin
            assert (!(cli_read[gnt] && cli_write[gnt]))
                else $error("client %0d asserted read and write together; write taken", gnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arb_n.sv
// Directed bench for mem_arb_n: a fixed-priority and a round-robin instance share stimulus;
// a scoreboard monitor checks every acceptance and every read-data return of the selected one.
module tb_mem_arb_n;
    localparam int N   = 3;
    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int BEW = 2;
    localparam int MP  = 4;
    localparam int CW  = 3;

    typedef struct {int c; logic [AW-1:0] a; logic w; logic [DW-1:0] d;} acc_t;
    typedef struct {int c; logic [DW-1:0] d;} ret_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [N*AW-1:0]  cli_address = '0;
    logic [N*BEW-1:0] cli_byteenable = '0;
    logic [N-1:0]     cli_read = '0;
    logic [N-1:0]     cli_write = '0;
    logic [N*DW-1:0]  cli_writedata = '0;
    logic             mem_waitrequest = 1'b0;
    logic [DW-1:0]    mem_readdata = '0;
    logic             mem_readdataready = 1'b0;

    logic [N-1:0] fx_wait, rr_wait, fx_rdr, rr_rdr;
    logic [DW-1:0] fx_rdata, rr_rdata, fx_wdata, rr_wdata;
    logic [AW-1:0] fx_addr, rr_addr;
    logic [BEW-1:0] fx_be, rr_be;
    logic fx_rd, rr_rd, fx_wr, rr_wr, fx_err, rr_err;
    logic [CW-1:0] fx_pc, rr_pc;

    logic sel_rr = 1'b0;
    logic slave_auto = 1'b0;
    logic cap_v = 1'b0, st_v = 1'b0;
    logic [DW-1:0] cap_d = '0, st_d = '0;

    int checks = 0;
    int failures = 0;
    acc_t exp_acc[$];
    ret_t exp_ret[$];
    acc_t mon_e;
    ret_t mon_r;

    logic [N-1:0]  m_wait, m_rdr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_rd, m_wr;

    always #5 clock = ~clock;

    mem_arb_n #(.N_CLIENTS(N), .AW(AW), .DW(DW), .MAX_PENDING(MP), .ARB_MODE(0)) u_fx (
        .clock(clock), .reset_n(reset_n), .cli_address(cli_address),
        .cli_byteenable(cli_byteenable), .cli_read(cli_read), .cli_write(cli_write),
        .cli_writedata(cli_writedata), .cli_waitrequest(fx_wait), .cli_readdata(fx_rdata),
        .cli_readdataready(fx_rdr), .mem_address(fx_addr), .mem_byteenable(fx_be),
        .mem_read(fx_rd), .mem_write(fx_wr), .mem_writedata(fx_wdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdataready(mem_readdataready), .pending_count(fx_pc), .err_unexpected(fx_err));

    mem_arb_n #(.N_CLIENTS(N), .AW(AW), .DW(DW), .MAX_PENDING(MP), .ARB_MODE(1)) u_rr (
        .clock(clock), .reset_n(reset_n), .cli_address(cli_address),
        .cli_byteenable(cli_byteenable), .cli_read(cli_read), .cli_write(cli_write),
        .cli_writedata(cli_writedata), .cli_waitrequest(rr_wait), .cli_readdata(rr_rdata),
        .cli_readdataready(rr_rdr), .mem_address(rr_addr), .mem_byteenable(rr_be),
        .mem_read(rr_rd), .mem_write(rr_wr), .mem_writedata(rr_wdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdataready(mem_readdataready), .pending_count(rr_pc), .err_unexpected(rr_err));

    assign m_wait  = sel_rr ? rr_wait  : fx_wait;
    assign m_rdr   = sel_rr ? rr_rdr   : fx_rdr;
    assign m_addr  = sel_rr ? rr_addr  : fx_addr;
    assign m_wdata = sel_rr ? rr_wdata : fx_wdata;
    assign m_rdata = sel_rr ? rr_rdata : fx_rdata;
    assign m_rd    = sel_rr ? rr_rd    : fx_rd;
    assign m_wr    = sel_rr ? rr_wr    : fx_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cli(input int c, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        cli_read[c] = rd;
        cli_write[c] = wr;
        cli_address[c*AW +: AW] = a;
        cli_writedata[c*DW +: DW] = d;
        cli_byteenable[c*BEW +: BEW] = (rd | wr) ? 2'b11 : 2'b00;
    endtask

    task automatic push_acc(input int c, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        acc_t e;
        e.c = c; e.a = a; e.w = w; e.d = d;
        exp_acc.push_back(e);
    endtask

    task automatic push_ret(input int c, input logic [DW-1:0] d);
        ret_t r;
        r.c = c; r.d = d;
        exp_ret.push_back(r);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every acceptance and every routed return must match the next expectation.
    always @(negedge clock) begin
        if (reset_n && m_wait != 3'b111) begin
            if (exp_acc.size() == 0) begin
                check("acc_unexpected", 64'(m_wait), 64'(3'b111));
            end else begin
                mon_e = exp_acc.pop_front();
                check("acc", {m_wait, m_addr, m_wr, m_rd, (m_wr ? m_wdata : 16'h0)},
                      {~(3'b001 << mon_e.c), mon_e.a, mon_e.w, ~mon_e.w, (mon_e.w ? mon_e.d : 16'h0)});
            end
        end
        if (m_rdr != '0) begin
            if (exp_ret.size() == 0) begin
                check("ret_unexpected", 64'(m_rdr), 64'(0));
            end else begin
                mon_r = exp_ret.pop_front();
                check("ret", {m_rdr, m_rdata}, {3'(3'b001 << mon_r.c), mon_r.d});
            end
        end
    end

    // Slave model: read data 0xA000+addr two cycles after acceptance.
    always @(negedge clock) begin
        cap_v = slave_auto && reset_n && (m_wait != 3'b111) && m_rd;
        cap_d = 16'hA000 + m_addr[15:0];
    end

    always @(posedge clock) begin
        if (slave_auto) begin
            #1;
            mem_readdataready = st_v;
            mem_readdata = st_d;
            st_v = cap_v;
            st_d = cap_d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_state", {fx_wait, fx_rd, fx_wr, fx_pc, fx_err, rr_pc, rr_err},
              {3'b111, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0});

        // Fixed priority: clients 0 and 2 write together.
        step();
        set_cli(0, 1'b0, 1'b1, 20'h00010, 16'h1111);
        set_cli(2, 1'b0, 1'b1, 20'h00030, 16'h3333);
        push_acc(0, 20'h00010, 1'b1, 16'h1111);
        push_acc(2, 20'h00030, 1'b1, 16'h3333);
        @(negedge clock);
        check("fp_addr_c1", 64'(fx_addr), 64'(20'h00010));
        step();
        set_cli(0, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge clock);
        check("fp_addr_c2", 64'(fx_addr), 64'(20'h00030));
        step();
        set_cli(2, 1'b0, 1'b0, 20'h0, 16'h0);
        step();
        check("fp_drained", 64'(exp_acc.size()), 64'(0));

        // Stall lock: client 1 held through 5 waitrequest cycles, client 0 waits.
        set_cli(1, 1'b0, 1'b1, 20'h00020, 16'h2222);
        mem_waitrequest = 1'b1;
        push_acc(1, 20'h00020, 1'b1, 16'h2222);
        push_acc(0, 20'h00010, 1'b1, 16'h1111);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) set_cli(0, 1'b0, 1'b1, 20'h00010, 16'h1111);
            if (i == 5) mem_waitrequest = 1'b0;
            @(negedge clock);
            check("lock_hold", {fx_addr, fx_wdata, fx_wr}, {20'h00020, 16'h2222, 1'b1});
            step();
        end
        set_cli(1, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge clock);
        check("lock_next", 64'(fx_addr), 64'(20'h00010));
        step();
        set_cli(0, 1'b0, 1'b0, 20'h0, 16'h0);
        step();
        check("lock_drained", 64'(exp_acc.size()), 64'(0));

        // Round robin: three continuous readers, slave returns after 2 cycles.
        pulse_reset();
        sel_rr = 1'b1;
        slave_auto = 1'b1;
        step();
        for (int c = 0; c < N; c++) set_cli(c, 1'b1, 1'b0, 20'(20'h10 * (c + 1)), 16'h0);
        for (int k = 0; k < 6; k++) begin
            push_acc(k % 3, 20'(20'h10 * (k % 3 + 1)), 1'b0, 16'h0);
            push_ret(k % 3, 16'(16'hA000 + 16'h10 * (k % 3 + 1)));
        end
        repeat (6) step();
        for (int c = 0; c < N; c++) set_cli(c, 1'b0, 1'b0, 20'h0, 16'h0);
        repeat (4) step();
        check("rr_drained", 64'(exp_acc.size() + exp_ret.size()), 64'(0));
        slave_auto = 1'b0;
        step();
        mem_readdataready = 1'b0;
        sel_rr = 1'b0;
        pulse_reset();

        // Pending full: reads stop at 4 outstanding, writes still pass.
        step();
        set_cli(0, 1'b1, 1'b0, 20'h00040, 16'h0);
        set_cli(1, 1'b0, 1'b1, 20'h00050, 16'h5050);
        for (int k = 0; k < 4; k++) push_acc(0, 20'h00040, 1'b0, 16'h0);
        push_acc(1, 20'h00050, 1'b1, 16'h5050);
        push_acc(0, 20'h00040, 1'b0, 16'h0);
        push_ret(0, 16'h5555);
        repeat (4) step();
        @(negedge clock);
        check("pf_count_full", 64'(fx_pc), 64'(4));
        step();
        set_cli(1, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge clock);
        check("pf_read_masked", {fx_wait[0], fx_rd}, {1'b1, 1'b0});
        step();
        mem_readdataready = 1'b1;
        mem_readdata = 16'h5555;
        @(negedge clock);
        check("pf_pop_no_unmask", 64'(fx_wait[0]), 64'(1));
        step();
        mem_readdataready = 1'b0;
        @(negedge clock);
        check("pf_count_after_pop", 64'(fx_pc), 64'(3));
        step();
        @(negedge clock);
        check("pf_refull", {fx_pc, fx_wait[0]}, {3'd4, 1'b1});
        step();
        set_cli(0, 1'b0, 1'b0, 20'h0, 16'h0);
        step();
        check("pf_drained", 64'(exp_acc.size() + exp_ret.size()), 64'(0));

        // Unexpected read data with nothing outstanding.
        pulse_reset();
        step();
        mem_readdataready = 1'b1;
        mem_readdata = 16'hBEEF;
        @(negedge clock);
        check("ue_no_route", 64'(fx_rdr), 64'(0));
        step();
        mem_readdataready = 1'b0;
        @(negedge clock);
        check("ue_err_set", 64'(fx_err), 64'(1));
        repeat (3) step();
        check("ue_err_sticky", 64'(fx_err), 64'(1));
        pulse_reset();
        #1;
        check("ue_err_cleared", 64'(fx_err), 64'(0));

        // Reset mid-operation with 3 reads outstanding and a stalled 4th.
        step();
        set_cli(0, 1'b1, 1'b0, 20'h00060, 16'h0);
        for (int k = 0; k < 3; k++) push_acc(0, 20'h00060, 1'b0, 16'h0);
        repeat (3) step();
        mem_waitrequest = 1'b1;
        @(negedge clock);
        check("rm_pending", {fx_pc, fx_rd}, {3'd3, 1'b1});
        #1;
        reset_n = 1'b0;
        #1;
        check("rm_async", {fx_pc, fx_rd, fx_wr, fx_wait, fx_rdr}, {3'd0, 1'b0, 1'b0, 3'b111, 3'b000});
        @(negedge clock);
        check("rm_wait_in_reset", 64'(fx_wait), 64'(3'b111));
        step();
        set_cli(0, 1'b0, 1'b0, 20'h0, 16'h0);
        mem_waitrequest = 1'b0;
        reset_n = 1'b1;
        step();
        mem_readdataready = 1'b1;
        mem_readdata = 16'h6666;
        @(negedge clock);
        check("rm_late_no_route", 64'(fx_rdr), 64'(0));
        step();
        mem_readdataready = 1'b0;
        @(negedge clock);
        check("rm_late_err", {fx_err, fx_pc}, {1'b1, 3'd0});
        check("rm_drained", 64'(exp_acc.size() + exp_ret.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arb_n.md
Name: mem_arb_n

Overview:
- N-client arbiter onto the single Avalon-style SRAM master bus feeding sram_arb_sync.
- Parametrised successor of the fixed two-port stim/check memory interface. Any client may issue reads and writes.
- Selectable fixed-priority or round-robin arbitration.
- Tracks pipelined reads in an ordered tag FIFO so readdataready is routed back to the issuing client.

Parameters:
- N_CLIENTS, 2, number of client ports (2..8).
- AW, 20, address width.
- DW, 16, data width; byteenable width BEW = DW/8 (derived, not overridable).
- MAX_PENDING, 4, maximum outstanding accepted reads (power of 2, >=2).
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.

Ports:
- clock  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cli_address  in  N_CLIENTS*AW  client c at [c*AW +: AW].
- cli_byteenable  in  N_CLIENTS*BEW  per-client byte enables.
- cli_read  in  N_CLIENTS  per-client read request.
- cli_write  in  N_CLIENTS  per-client write request.
- cli_writedata  in  N_CLIENTS*DW  per-client write data.
- cli_waitrequest  out  N_CLIENTS  low exactly in the cycle the client's transfer is accepted.
- cli_readdata  out  DW  broadcast copy of mem_readdata.
- cli_readdataready  out  N_CLIENTS  one-hot return strobe to the issuing client.
- mem_address  out  AW  master address.
- mem_byteenable  out  BEW  master byte enables.
- mem_read  out  1  master read.
- mem_write  out  1  master write.
- mem_writedata  out  DW  master write data.
- mem_waitrequest  in  1  slave stall.
- mem_readdata  in  DW  slave read data.
- mem_readdataready  in  1  slave read-data valid.
- pending_count  out  $clog2(MAX_PENDING+1)  outstanding reads.
- err_unexpected  out  1  sticky: readdataready arrived with no read outstanding.

Behaviour:
- Reset (async assert, sync release):
  - tag FIFO emptied; pending_count = 0; locked = 0; rr_ptr = 0; err_unexpected = 0.
  - While reset_n is low: mem_read = mem_write = 0, cli_waitrequest = all 1, cli_readdataready = 0.
- Request of client c: req[c] = cli_write[c] | (cli_read[c] & ~pend_full). Reads are masked while MAX_PENDING reads are outstanding; writes still proceed.
- Grant selection:
  - If locked, gnt = gnt_q.
  - Otherwise gnt is chosen combinationally from req.
  - Mode 0: lowest index wins. Mode 1: first requester at or after rr_ptr, wrapping modulo N_CLIENTS.
- Master bus:
  - Driven combinationally from the granted client; zeros when no grant.
  - If a client asserts read and write together: write wins, the read is ignored, and a simulation-only assertion fires.
- Acceptance: acc = granted & (mem_read | mem_write) & ~mem_waitrequest. cli_waitrequest[gnt] = ~acc; all other bits = 1. Zero-latency handshake; back-to-back transfers possible every cycle.
- Lock:
  - If granted and not accepted, then locked <= 1 and gnt_q <= gnt. Grant is held until acceptance, so the master signals stay stable under waitrequest.
  - locked <= 0 on acc.
- Round robin: on acc, rr_ptr <= (gnt+1) mod N_CLIENTS. rr_ptr does not move without acceptance.
- Read tracking:
  - An accepted read pushes gnt into the tag FIFO.
  - mem_readdataready pops the head; cli_readdataready[head] = 1 in the same cycle; cli_readdata = mem_readdata combinationally.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop while empty: no routing, err_unexpected <= 1 (held until reset).
  - pend_full = (pending_count == MAX_PENDING). A pop in the same cycle does not unmask reads; this keeps the full path registered-only.
- Writes: no response phase; nothing is pushed.
- Reset mid-transfer: outstanding tags are discarded. Late readdataready after reset sets err_unexpected.

Decomposition:
- Package mem_arb_pkg:
  - arb_mode_e {ARB_FIXED=0, ARB_RR=1}.
  - Helper function first_set_from(vector, start) used by both arbitration modes.
- Sub-module mem_arb_tag_fifo: synchronous FIFO, width $clog2(N_CLIENTS) (min 1), depth MAX_PENDING, with push, pop, head, count, empty and full.
- Arbiter and lock logic stay in mem_arb_n.

Test Plan:
- Fixed priority: N=3, clients 0 and 2 both write, mem_waitrequest=0 → client 0 accepted in cycle 1, client 2 in cycle 2, mem_address follows 0x00010 then 0x00030.
- Round robin: ARB_MODE=1, all three clients read continuously, slave returns data 2 cycles later → grant order 0,1,2,0,…; readdataready strobes return one-hot in the same order with the correct data (0xA000+addr).
- Stall lock: client 1 write granted, mem_waitrequest high for 5 cycles while client 0 also requests → mem_address/writedata stay at client 1 values for 6 cycles; client 0 is granted only after acceptance.
- Pending full: MAX_PENDING=4, slave withholds readdataready, client 0 issues 6 reads and client 1 one write → 4 reads accepted, pending_count=4, client 1 write still accepted; after 1 pop the 5th read is accepted the following cycle.
- Unexpected data: pulse mem_readdataready with pending_count=0 → no cli_readdataready bit set, err_unexpected=1 until reset_n pulse.
- Reset mid-operation: reset asserted with 3 reads pending → pending_count=0 and mem_read=0 asynchronously; cli_waitrequest=all 1 during reset.
